multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle successor to the single-cycle MIPS controller: Moore FSM sequencing fetch/decode/execute/memory/writeback over a shared memory and ALU.
- Sits between instruction register (op/funct) and the multicycle datapath; drives mux selects, write enables and ALU control each cycle.
- Adds a memory ready handshake, jump, and an illegal-opcode flag; ALU control width is parametrised.

Parameters:
ALUCTL_W, 3, ALUControl width; encodings 0..7 = add, sub, and, or, xor, nor, slt, sltu (zero-extended if wider).
CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  instruction opcode from IR
funct  in  6  R-type function field from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction register load
RegDst  out  1  write-register select: 1 = rd, 0 = rt
MemtoReg  out  1  writeback data select: 1 = MDR
RegWrite  out  1  register file write
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs
ALUSrcB  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign/zero-extended imm, 11 = imm<<2
SgnZero  out  1  1 = sign-extend imm, 0 = zero-extend
ALUControl  out  ALUCTL_W  ALU operation
PCSrc  out  2  next PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
PCEn  out  1  PC write enable, branch condition already folded in
illegal  out  1  one-cycle pulse on unsupported op/funct

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, ITEXEC, ITWB, BRANCH, JUMP.
- Register: state only. All outputs are combinational from state, plus op/funct and zero/mem_ready where noted. Any output not listed for a state is 0.
- Reset: asynchronous to FETCH while rst_n = 0. Outputs then equal FETCH decode with mem_ready gating, so nothing writes during reset. Reset mid-instruction abandons it without any write.
- FETCH:
  - IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUControl = add, PCSrc = 00.
  - IRWrite = PCEn = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 11, SgnZero = 1, add (branch target into ALUOut).
  - Transitions: lw/sw -> MEMADR; op = 0 with a legal funct -> RTEXEC; addi/addiu/andi/ori/xori/slti/sltiu -> ITEXEC; beq/bne -> BRANCH; j (000010) -> JUMP.
  - Any other op, or op = 0 with an illegal funct: illegal = 1, go to FETCH.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, SgnZero = 1, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: IorD = 1; hold until mem_ready = 1, then MEMWB.
- MEMWB: RegDst = 0, MemtoReg = 1, RegWrite = 1; go to FETCH.
- MEMWR: IorD = 1, MemWrite = mem_ready; hold until mem_ready = 1, then FETCH.
- RTEXEC: ALUSrcA = 1, ALUSrcB = 00, ALUControl from funct (add/addu, sub/subu, and, or, xor, nor, slt, sltu); go to RTWB.
- RTWB: RegDst = 1, RegWrite = 1, ALUControl held; go to FETCH.
- ITEXEC:
  - ALUSrcA = 1, ALUSrcB = 10.
  - SgnZero = 0 for andi/ori/xori, 1 otherwise.
  - ALUControl: addi/addiu add, andi and, ori or, xori xor, slti slt, sltiu sltu. sltiu is op 001011, distinct from addiu 001001.
  - Go to ITWB.
- ITWB: RegDst = 0, RegWrite = 1, ALUControl and SgnZero held; go to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, sub, PCSrc = 01. PCEn = zero for beq, ~zero for bne. Go to FETCH.
- JUMP: PCSrc = 10, PCEn = 1; go to FETCH.
- Cycle counts with mem_ready always 1:
  - j, beq, bne, illegal: 3 or fewer (illegal takes 2).
  - R-type, I-type, sw: 4.
  - lw: 5.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- Simultaneous events: mem_ready outside FETCH, MEMRD and MEMWR is ignored. op/funct must be stable from DECODE until return to FETCH; the IR guarantees this.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined:
  - Adds outputs instr_count and cycle_count, each CNT_W wide.
  - Both reset to 0. cycle_count increments every cycle out of reset.
  - instr_count increments on each transition into FETCH from a non-FETCH state, including illegal.
  - Both wrap modulo 2^CNT_W.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - State enum (4-bit encoding).
  - Opcode and funct localparams.
  - ALU op encodings.
  - ALUSrcB and PCSrc select encodings.
- One sub-module, alu_decoder (combinational): maps op, funct and state class to ALUControl and SgnZero, and flags an illegal funct. Shared with the single-cycle path.

Test Plan:
- Reset asserted during MEMRD of lw, then released: state FETCH, RegWrite = 0 throughout; first FETCH cycle IorD = 0, ALUSrcB = 01.
- add (funct 100000), mem_ready = 1: FETCH, DECODE, RTEXEC, RTWB; RegWrite = 1 and RegDst = 1 only in cycle 4; ALUControl = 000.
- lw with mem_ready low 2 cycles in MEMRD: 7 cycles total; MemtoReg = 1 and RegWrite = 1 in the final cycle only.
- beq with zero = 1, then bne with zero = 1: PCEn = 1 in BRANCH for beq, 0 for bne; PCSrc = 01.
- andi and sltiu: SgnZero = 0 with ALUControl = 010, then SgnZero = 1 with ALUControl = 111.
- op = 111111: illegal pulses 1 cycle in DECODE, next state FETCH, no RegWrite or MemWrite; under the macro, instr_count increments by 1.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller and its ALU decoder.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StRtExec,
    StRtWb,
    StItExec,
    StItWb,
    StBranch,
    StJump
  } state_e;

  // Which source the ALU operation is taken from in the current state.
  typedef enum logic [1:0] {
    ClsAdd,
    ClsSub,
    ClsFunct,
    ClsOp
  } alu_cls_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSltu = 6'b101011;

  localparam logic [2:0] AluAdd  = 3'd0;
  localparam logic [2:0] AluSub  = 3'd1;
  localparam logic [2:0] AluAnd  = 3'd2;
  localparam logic [2:0] AluOr   = 3'd3;
  localparam logic [2:0] AluXor  = 3'd4;
  localparam logic [2:0] AluNor  = 3'd5;
  localparam logic [2:0] AluSlt  = 3'd6;
  localparam logic [2:0] AluSltu = 3'd7;

  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OpAddi) || (op == OpAddiu) || (op == OpAndi) || (op == OpOri) ||
           (op == OpXori) || (op == OpSlti) || (op == OpSltiu);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: picks the ALU operation from op/funct by state class,
// gives the immediate extension mode and flags an unsupported R-type funct.
module alu_decoder
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTL_W = 3
) (
  input  logic [5:0]          i_op,
  input  logic [5:0]          i_funct,
  input  alu_cls_e            i_cls,
  output logic [ALUCTL_W-1:0] o_alu_ctl,
  output logic                o_sgn_zero,
  output logic                o_funct_illegal
);

  logic [2:0] w_funct_op;
  logic [2:0] w_imm_op;
  logic [2:0] w_alu_op;

  always_comb begin
    w_funct_op      = AluAdd;
    o_funct_illegal = 1'b0;
    case (i_funct)
      FnAdd, FnAddu: w_funct_op = AluAdd;
      FnSub, FnSubu: w_funct_op = AluSub;
      FnAnd:         w_funct_op = AluAnd;
      FnOr:          w_funct_op = AluOr;
      FnXor:         w_funct_op = AluXor;
      FnNor:         w_funct_op = AluNor;
      FnSlt:         w_funct_op = AluSlt;
      FnSltu:        w_funct_op = AluSltu;
      default:       o_funct_illegal = 1'b1;
    endcase
  end

  // Logical immediates are zero-extended; arithmetic and compare ones are sign-extended.
  always_comb begin
    w_imm_op   = AluAdd;
    o_sgn_zero = 1'b1;
    case (i_op)
      OpAndi: begin
        w_imm_op   = AluAnd;
        o_sgn_zero = 1'b0;
      end
      OpOri: begin
        w_imm_op   = AluOr;
        o_sgn_zero = 1'b0;
      end
      OpXori: begin
        w_imm_op   = AluXor;
        o_sgn_zero = 1'b0;
      end
      OpSlti:  w_imm_op = AluSlt;
      OpSltiu: w_imm_op = AluSltu;
      default: w_imm_op = AluAdd;
    endcase
  end

  always_comb begin
    w_alu_op = AluAdd;
    case (i_cls)
      ClsSub:   w_alu_op = AluSub;
      ClsFunct: w_alu_op = w_funct_op;
      ClsOp:    w_alu_op = w_imm_op;
      default:  w_alu_op = AluAdd;
    endcase
  end

  assign o_alu_ctl = ALUCTL_W'(w_alu_op);

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style multicycle MIPS controller. Define MULTICYCLE_CTRL_PERF_EN to add the
// instr_count/cycle_count performance counters.
module multicycle_controller
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTL_W = 3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                SgnZero,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [1:0]          PCSrc,
  output logic                PCEn,
  output logic                illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]    instr_count,
  output logic [CNT_W-1:0]    cycle_count
`endif
);

  state_e              r_state;
  state_e              w_state_d;
  alu_cls_e            w_alu_cls;
  logic [ALUCTL_W-1:0] w_alu_ctl;
  logic                w_imm_sgn;
  logic                w_funct_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StFetch;
    else        r_state <= w_state_d;
  end

  always_comb begin
    case (r_state)
      StRtExec, StRtWb: w_alu_cls = ClsFunct;
      StItExec, StItWb: w_alu_cls = ClsOp;
      StBranch:         w_alu_cls = ClsSub;
      default:          w_alu_cls = ClsAdd;
    endcase
  end

  alu_decoder #(
    .ALUCTL_W(ALUCTL_W)
  ) u_alu_decoder (
    .i_op           (op),
    .i_funct        (funct),
    .i_cls          (w_alu_cls),
    .o_alu_ctl      (w_alu_ctl),
    .o_sgn_zero     (w_imm_sgn),
    .o_funct_illegal(w_funct_illegal)
  );

  always_comb begin
    w_state_d  = r_state;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SrcBReg;
    SgnZero    = 1'b0;
    ALUControl = w_alu_ctl;
    PCSrc      = PcSrcAlu;
    PCEn       = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      StFetch: begin
        ALUSrcB = SrcBFour;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
        if (mem_ready) w_state_d = StDecode;
      end
      StDecode: begin
        ALUSrcB = SrcBImmSh2;
        SgnZero = 1'b1;
        if (op == OpLw || op == OpSw)              w_state_d = StMemAdr;
        else if (op == OpRtype && !w_funct_illegal) w_state_d = StRtExec;
        else if (is_itype(op))                      w_state_d = StItExec;
        else if (op == OpBeq || op == OpBne)        w_state_d = StBranch;
        else if (op == OpJ)                         w_state_d = StJump;
        else begin
          illegal   = 1'b1;
          w_state_d = StFetch;
        end
      end
      StMemAdr: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SrcBImm;
        SgnZero   = 1'b1;
        w_state_d = (op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        IorD = 1'b1;
        if (mem_ready) w_state_d = StMemWb;
      end
      StMemWb: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        w_state_d = StFetch;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = mem_ready;
        if (mem_ready) w_state_d = StFetch;
      end
      StRtExec: begin
        ALUSrcA   = 1'b1;
        w_state_d = StRtWb;
      end
      StRtWb: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        w_state_d = StFetch;
      end
      StItExec: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SrcBImm;
        SgnZero   = w_imm_sgn;
        w_state_d = StItWb;
      end
      StItWb: begin
        RegWrite  = 1'b1;
        SgnZero   = w_imm_sgn;
        w_state_d = StFetch;
      end
      StBranch: begin
        ALUSrcA   = 1'b1;
        PCSrc     = PcSrcAluOut;
        PCEn      = (op == OpBeq) ? zero : ~zero;
        w_state_d = StFetch;
      end
      StJump: begin
        PCSrc     = PcSrcJump;
        PCEn      = 1'b1;
        w_state_d = StFetch;
      end
      default: w_state_d = StFetch;
    endcase
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_instr_count;
  logic [CNT_W-1:0] r_cycle_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_count <= '0;
      r_cycle_count <= '0;
    end else begin
      r_cycle_count <= r_cycle_count + CNT_W'(1);
      // Every instruction, illegal ones included, retires by returning to FETCH.
      if (r_state != StFetch && w_state_d == StFetch) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  assign instr_count = r_instr_count;
  assign cycle_count = r_cycle_count;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and randomized instructions compared
// cycle by cycle against a per-instruction phase list built from the instruction class.
module tb_multicycle_controller;

  localparam int KLw = 0, KSw = 1, KR = 2, KI = 3, KBr = 4, KJ = 5, KIll = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, SgnZero, PCEn, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] instr_count, cycle_count;
`endif

  int checks = 0;
  int failures = 0;
  int exp_instr = 0;
  int exp_cycles = 0;

  // One phase of an instruction; memw/irw/pcen_mr mean "active exactly when memory is ready".
  typedef struct packed {
    logic       wt;
    logic       iord, memw, irw, pcen_mr, regdst, memtoreg, regwrite, srca;
    logic [1:0] srcb;
    logic       sgn;
    logic [2:0] alu;
    logic [1:0] pcsrc;
    logic       pcen, ill;
  } step_t;

  step_t steps[$];

  multicycle_controller #(
    .ALUCTL_W(3),
    .CNT_W   (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .SgnZero   (SgnZero),
    .ALUControl(ALUControl),
    .PCSrc     (PCSrc),
    .PCEn      (PCEn),
    .illegal   (illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .instr_count(instr_count),
    .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] funct_alu(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 4'b1000;
      6'h22, 6'h23: return 4'b1001;
      6'h24:        return 4'b1010;
      6'h25:        return 4'b1011;
      6'h26:        return 4'b1100;
      6'h27:        return 4'b1101;
      6'h2a:        return 4'b1110;
      6'h2b:        return 4'b1111;
      default:      return 4'b0000;
    endcase
  endfunction

  // {valid, sign-extend, alu op} for immediate-form instructions.
  function automatic logic [4:0] imm_info(input logic [5:0] o);
    case (o)
      6'h08, 6'h09: return 5'b11000;
      6'h0c:        return 5'b10010;
      6'h0d:        return 5'b10011;
      6'h0e:        return 5'b10100;
      6'h0a:        return 5'b11110;
      6'h0b:        return 5'b11111;
      default:      return 5'b00000;
    endcase
  endfunction

  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    logic [3:0] fa;
    logic [4:0] ii;
    fa = funct_alu(f);
    ii = imm_info(o);
    if (o == 6'h23) return KLw;
    if (o == 6'h2b) return KSw;
    if (o == 6'h00) return fa[3] ? KR : KIll;
    if (ii[4]) return KI;
    if (o == 6'h04 || o == 6'h05) return KBr;
    if (o == 6'h02) return KJ;
    return KIll;
  endfunction

  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic zr);
    step_t s;
    int k;
    logic [3:0] fa;
    logic [4:0] ii;
    k = kind_of(o, f);
    fa = funct_alu(f);
    ii = imm_info(o);
    steps.delete();
    s = '0; s.wt = 1'b1; s.srcb = 2'b01; s.irw = 1'b1; s.pcen_mr = 1'b1;
    steps.push_back(s);
    s = '0; s.srcb = 2'b11; s.sgn = 1'b1; s.ill = (k == KIll);
    steps.push_back(s);
    if (k == KLw || k == KSw) begin
      s = '0; s.srca = 1'b1; s.srcb = 2'b10; s.sgn = 1'b1;
      steps.push_back(s);
    end
    case (k)
      KLw: begin
        s = '0; s.wt = 1'b1; s.iord = 1'b1; steps.push_back(s);
        s = '0; s.memtoreg = 1'b1; s.regwrite = 1'b1; steps.push_back(s);
      end
      KSw: begin
        s = '0; s.wt = 1'b1; s.iord = 1'b1; s.memw = 1'b1; steps.push_back(s);
      end
      KR: begin
        s = '0; s.srca = 1'b1; s.alu = fa[2:0]; steps.push_back(s);
        s = '0; s.regdst = 1'b1; s.regwrite = 1'b1; s.alu = fa[2:0]; steps.push_back(s);
      end
      KI: begin
        s = '0; s.srca = 1'b1; s.srcb = 2'b10; s.sgn = ii[3]; s.alu = ii[2:0];
        steps.push_back(s);
        s = '0; s.regwrite = 1'b1; s.sgn = ii[3]; s.alu = ii[2:0]; steps.push_back(s);
      end
      KBr: begin
        s = '0; s.srca = 1'b1; s.alu = 3'd1; s.pcsrc = 2'b01;
        s.pcen = (o == 6'h04) ? zr : ~zr;
        steps.push_back(s);
      end
      KJ: begin
        s = '0; s.pcsrc = 2'b10; s.pcen = 1'b1; steps.push_back(s);
      end
      default: ;
    endcase
  endtask

  task automatic cycle(input string tag, input step_t s, input logic mr);
    logic [16:0] obs, expv;
    mem_ready = mr;
    @(negedge clk);
    obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, SgnZero,
           ALUControl, PCSrc, PCEn, illegal};
    expv = {s.iord, s.memw & mr, s.irw & mr, s.regdst, s.memtoreg, s.regwrite, s.srca, s.srcb,
            s.sgn, s.alu, s.pcsrc, s.pcen | (s.pcen_mr & mr), s.ill};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s outputs observed=%05h expected=%05h", tag, obs, expv);
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    checks++;
    assert (instr_count === 32'(exp_instr)) else begin
      failures++;
      $error("FAIL %s instr_count observed=%0d expected=%0d", tag, instr_count, exp_instr);
    end
    checks++;
    assert (cycle_count === 32'(exp_cycles)) else begin
      failures++;
      $error("FAIL %s cycle_count observed=%0d expected=%0d", tag, cycle_count, exp_cycles);
    end
`endif
    @(posedge clk);
    if (rst_n) exp_cycles++;
    #1;
  endtask

  // Stalls: fstall low cycles in FETCH, mstall low cycles in MEMRD/MEMWR.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic zr, input int fstall, input int mstall);
    build(o, f, zr);
    op = o;
    funct = f;
    zero = zr;
    for (int i = 0; i < steps.size(); i++) begin
      if (steps[i].wt) begin
        repeat ((i == 0) ? fstall : mstall) cycle($sformatf("%s.p%0d", name, i), steps[i], 1'b0);
        cycle($sformatf("%s.p%0d", name, i), steps[i], 1'b1);
      end else begin
        cycle($sformatf("%s.p%0d", name, i), steps[i], 1'($urandom_range(0, 1)));
      end
    end
    exp_instr++;
  endtask

  initial begin
    logic [5:0] ops[16];
    logic [5:0] fns[10];
    logic [5:0] o, f;
    ops = '{6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
            6'h0e, 6'h23, 6'h2b, 6'h3f, 6'h01};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};

    build(6'h00, 6'h20, 1'b0);
    cycle("reset0", steps[0], 1'b0);
    cycle("reset1", steps[0], 1'b0);
    rst_n = 1'b1;

    run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
    run_instr("lw_stall", 6'h23, 6'h00, 1'b0, 0, 2);
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0);
    run_instr("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0);
    run_instr("andi", 6'h0c, 6'h00, 1'b0, 0, 0);
    run_instr("sltiu", 6'h0b, 6'h00, 1'b0, 0, 0);
    run_instr("illegal_op", 6'h3f, 6'h00, 1'b0, 0, 0);
    run_instr("illegal_fn", 6'h00, 6'h01, 1'b0, 1, 0);
    run_instr("sw_stall", 6'h2b, 6'h00, 1'b0, 1, 2);
    run_instr("j", 6'h02, 6'h00, 1'b0, 0, 0);

    // Reset during MEMRD of a lw must abandon it with no register write.
    build(6'h23, 6'h00, 1'b0);
    op = 6'h23;
    cycle("rst_lw.fetch", steps[0], 1'b1);
    cycle("rst_lw.decode", steps[1], 1'b1);
    cycle("rst_lw.memadr", steps[2], 1'b0);
    cycle("rst_lw.memrd", steps[3], 1'b0);
    rst_n = 1'b0;
    exp_instr = 0;
    exp_cycles = 0;
    build(6'h23, 6'h00, 1'b0);
    cycle("rst_lw.inrst0", steps[0], 1'b0);
    cycle("rst_lw.inrst1", steps[0], 1'b0);
    rst_n = 1'b1;
    run_instr("after_rst", 6'h00, 6'h22, 1'b0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      o = ops[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) o = 6'($urandom);
      f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 9)];
      run_instr($sformatf("rnd%0d_op%02h_fn%02h", n, o, f), o, f, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
